// File: rtl/rtc_bus_sequencer.sv
// rtc_bus_sequencer
// Runs single-byte read/write transactions on the RTC chip's multiplexed
// address/data bus. Each transaction has an address strobe, a gap, a data
// strobe and a second gap. Every output is registered. Outputs are decoded
// from the next state, so they change on the same edge as the state.
module rtc_bus_sequencer #(
    parameter int unsigned T_STROBE = 8,
    parameter int unsigned T_GAP    = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       req_wr,
    input  logic       req_rd,
    input  logic [7:0] addr,
    input  logic [7:0] wr_data,
    output logic [7:0] rd_data,
    output logic       busy,
    output logic       done,
    output logic       cs_n,
    output logic       wr_n,
    output logic       rd_n,
    output logic       ad_n,
    output logic       ad_oe,
    output logic [7:0] ad_out,
    input  logic [7:0] ad_in
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_A_STB = 3'd1;
    localparam logic [2:0] S_A_GAP = 3'd2;
    localparam logic [2:0] S_D_STB = 3'd3;
    localparam logic [2:0] S_D_GAP = 3'd4;

    // The phase counter counts down to zero. Loading it with T-1 gives T cycles per phase.
    localparam logic [7:0] STB_LOAD = 8'(T_STROBE - 1);
    localparam logic [7:0] GAP_LOAD = 8'(T_GAP - 1);

    logic [2:0] state;
    logic [2:0] state_nx;
    logic [7:0] cnt;
    logic [7:0] cnt_nx;

    // Operands latched when a request is accepted. op_wr=1 selects a write.
    logic       op_wr;
    logic       op_wr_nx;
    logic [7:0] op_addr;
    logic [7:0] op_addr_nx;
    logic [7:0] op_data;
    logic [7:0] op_data_nx;

    logic       capture;
    logic       done_nx;
    logic       busy_nx;
    logic       cs_n_nx;
    logic       wr_n_nx;
    logic       rd_n_nx;
    logic       ad_n_nx;
    logic       ad_oe_nx;
    logic [7:0] ad_out_nx;

    // Next-state, phase-counter and operand-latch logic
    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        op_wr_nx   = op_wr;
        op_addr_nx = op_addr;
        op_data_nx = op_data;
        capture    = 1'b0;
        done_nx    = 1'b0;
        case (state)
            S_IDLE: begin
                // If both requests are high, the write is taken and the read is dropped.
                if (req_wr || req_rd) begin
                    state_nx   = S_A_STB;
                    cnt_nx     = STB_LOAD;
                    op_wr_nx   = req_wr;
                    op_addr_nx = addr;
                    op_data_nx = wr_data;
                end
            end
            S_A_STB: begin
                if (cnt == 8'd0) begin
                    state_nx = S_A_GAP;
                    cnt_nx   = GAP_LOAD;
                end else begin
                    cnt_nx = cnt - 8'd1;
                end
            end
            S_A_GAP: begin
                if (cnt == 8'd0) begin
                    state_nx = S_D_STB;
                    cnt_nx   = STB_LOAD;
                end else begin
                    cnt_nx = cnt - 8'd1;
                end
            end
            S_D_STB: begin
                if (cnt == 8'd0) begin
                    state_nx = S_D_GAP;
                    cnt_nx   = GAP_LOAD;
                    // Sample the pad on the edge that ends the last read-strobe cycle.
                    capture  = ~op_wr;
                end else begin
                    cnt_nx = cnt - 8'd1;
                end
            end
            S_D_GAP: begin
                if (cnt == 8'd0) begin
                    state_nx = S_IDLE;
                    cnt_nx   = 8'd0;
                    done_nx  = 1'b1;
                end else begin
                    cnt_nx = cnt - 8'd1;
                end
            end
            default: begin
                state_nx = S_IDLE;
                cnt_nx   = 8'd0;
            end
        endcase
    end

    // Bus pin values for the state being entered
    always_comb begin
        cs_n_nx   = 1'b1;
        wr_n_nx   = 1'b1;
        rd_n_nx   = 1'b1;
        ad_n_nx   = 1'b1;
        ad_oe_nx  = 1'b0;
        ad_out_nx = 8'h00;
        case (state_nx)
            S_A_STB: begin
                cs_n_nx   = 1'b0;
                ad_n_nx   = 1'b0;
                ad_oe_nx  = 1'b1;
                ad_out_nx = op_addr_nx;
                wr_n_nx   = ~op_wr_nx;
                rd_n_nx   = op_wr_nx;
            end
            S_A_GAP: begin
                // Keep driving the address after the strobe to give address hold time.
                ad_oe_nx  = 1'b1;
                ad_out_nx = op_addr_nx;
            end
            S_D_STB: begin
                cs_n_nx = 1'b0;
                if (op_wr_nx) begin
                    wr_n_nx   = 1'b0;
                    ad_oe_nx  = 1'b1;
                    ad_out_nx = op_data_nx;
                end else begin
                    // Release the bus on this edge. rd_n is already high from the gap.
                    rd_n_nx = 1'b0;
                end
            end
            S_D_GAP: begin
                if (op_wr_nx) begin
                    ad_oe_nx  = 1'b1;
                    ad_out_nx = op_data_nx;
                end
            end
            default: ;
        endcase
        busy_nx = (state_nx != S_IDLE);
    end

    // State, counter and registered outputs. Reset returns them all to idle.
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= S_IDLE;
            cnt     <= 8'd0;
            busy    <= 1'b0;
            done    <= 1'b0;
            cs_n    <= 1'b1;
            wr_n    <= 1'b1;
            rd_n    <= 1'b1;
            ad_n    <= 1'b1;
            ad_oe   <= 1'b0;
            ad_out  <= 8'h00;
            rd_data <= 8'h00;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            busy   <= busy_nx;
            done   <= done_nx;
            cs_n   <= cs_n_nx;
            wr_n   <= wr_n_nx;
            rd_n   <= rd_n_nx;
            ad_n   <= ad_n_nx;
            ad_oe  <= ad_oe_nx;
            ad_out <= ad_out_nx;
            if (capture) begin
                rd_data <= ad_in;
            end
        end
    end

    // Operand latches. They are only read while busy, so they need no reset.
    always_ff @(posedge clock) begin
        op_wr   <= op_wr_nx;
        op_addr <= op_addr_nx;
        op_data <= op_data_nx;
    end

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// tb_rtc_bus_sequencer
// Scoreboard bench. The stimulus pushes the expected transactions into queues.
// Monitor processes pop an entry when the bus activity starts. They then check
// the bus cycle by cycle against a phase table built from the default timing.
// A second instance with 1-cycle strobes and gaps runs the held-request case.
module tb_rtc_bus_sequencer;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       req_wr = 1'b0;
    logic       req_rd = 1'b0;
    logic [7:0] addr = 8'h00;
    logic [7:0] wr_data = 8'h00;
    logic [7:0] rd_data;
    logic       busy, done, cs_n, wr_n, rd_n, ad_n, ad_oe;
    logic [7:0] ad_out;
    logic [7:0] ad_in;
    logic [7:0] rd_val = 8'h00;

    logic       req_wr_f = 1'b0;
    logic [7:0] rd_data_f;
    logic       busy_f, done_f, cs_n_f, wr_n_f, rd_n_f, ad_n_f, ad_oe_f;
    logic [7:0] ad_out_f;

    int checks = 0;
    int errors = 0;
    logic mon_en = 1'b0;

    typedef struct {
        logic       wr;
        logic [7:0] addr;
        logic [7:0] data;
        logic [7:0] rd_exp;
        int         abort_cyc;
    } txn_t;

    txn_t sb_q[$];
    int   fast_q[$];

    localparam logic [12:0] IDLE_BUS = {4'b1111, 1'b0, 8'h00};

    always #5 clock = ~clock;

    // The RTC chip model drives the read byte only while it sees a data-phase
    // read strobe. At all other times the pad carries a filler pattern.
    assign ad_in = (!rd_n && ad_n) ? rd_val : 8'hA5;

    rtc_bus_sequencer dut (
        .clock(clock), .reset(reset), .req_wr(req_wr), .req_rd(req_rd),
        .addr(addr), .wr_data(wr_data), .rd_data(rd_data), .busy(busy),
        .done(done), .cs_n(cs_n), .wr_n(wr_n), .rd_n(rd_n), .ad_n(ad_n),
        .ad_oe(ad_oe), .ad_out(ad_out), .ad_in(ad_in)
    );

    rtc_bus_sequencer #(.T_STROBE(1), .T_GAP(1)) dut_f (
        .clock(clock), .reset(reset), .req_wr(req_wr_f), .req_rd(1'b0),
        .addr(8'h3C), .wr_data(8'h5A), .rd_data(rd_data_f), .busy(busy_f),
        .done(done_f), .cs_n(cs_n_f), .wr_n(wr_n_f), .rd_n(rd_n_f), .ad_n(ad_n_f),
        .ad_oe(ad_oe_f), .ad_out(ad_out_f), .ad_in(8'h00)
    );

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Expected {cs_n, wr_n, rd_n, ad_n, ad_oe, ad_out} in cycle c (1..24), default timing
    function automatic logic [12:0] exp_bus(input txn_t t, input int c);
        logic [12:0] v;
        if (c <= 8)
            v = {1'b0, ~t.wr, t.wr, 1'b0, 1'b1, t.addr};
        else if (c <= 12)
            v = {4'b1111, 1'b1, t.addr};
        else if (c <= 20)
            v = {1'b0, ~t.wr, t.wr, 1'b1, t.wr, (t.wr ? t.data : 8'h00)};
        else
            v = {4'b1111, t.wr, (t.wr ? t.data : 8'h00)};
        return v;
    endfunction

    // Main monitor
    txn_t       cur;
    logic       active = 1'b0;
    int         cyc = 0;
    logic [7:0] exp_rd = 8'h00;
    logic [12:0] bus;
    assign bus = {cs_n, wr_n, rd_n, ad_n, ad_oe, ad_out};

    always @(negedge clock) begin
        if (mon_en) begin
            if (!active && busy === 1'b1) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_txn: busy=%b with no queued request at %0t", busy, $time);
                end else begin
                    cur = sb_q.pop_front();
                    active = 1'b1;
                    cyc = 0;
                end
            end
            if (active) begin
                cyc++;
                if (cur.abort_cyc != 0 && cyc == cur.abort_cyc) begin
                    exp_rd = 8'h00;
                    check("reset_bus", 32'(bus), 32'(IDLE_BUS));
                    check("reset_busy", 32'(busy), 32'd0);
                    check("reset_done", 32'(done), 32'd0);
                    check("reset_rd_data", 32'(rd_data), 32'h00);
                    active = 1'b0;
                end else if (cyc <= 24) begin
                    if (!cur.wr && cyc == 21) exp_rd = cur.rd_exp;
                    check("busy", 32'(busy), 32'd1);
                    check("done_early", 32'(done), 32'd0);
                    check($sformatf("bus_c%0d", cyc), 32'(bus), 32'(exp_bus(cur, cyc)));
                    check($sformatf("rd_data_c%0d", cyc), 32'(rd_data), 32'(exp_rd));
                end else begin
                    check("done_c25", 32'(done), 32'd1);
                    check("busy_c25", 32'(busy), 32'd0);
                    check("bus_c25", 32'(bus), 32'(IDLE_BUS));
                    check("rd_data_c25", 32'(rd_data), 32'(exp_rd));
                    active = 1'b0;
                end
            end else if (busy !== 1'b1) begin
                check("idle_done", 32'(done), 32'd0);
                check("idle_bus", 32'(bus), 32'(IDLE_BUS));
                check("idle_rd_data", 32'(rd_data), 32'(exp_rd));
            end
        end
    end

    // Monitor for the fast instance
    int   run_f = 0;
    logic chk_next_f = 1'b0;
    int   follow_f = 0;

    always @(negedge clock) begin
        if (mon_en) begin
            if (chk_next_f) begin
                check("fast_after_done", {28'd0, cs_n_f, wr_n_f, busy_f, done_f},
                      (follow_f != 0) ? 32'b0010 : 32'b1100);
                chk_next_f = 1'b0;
            end
            if (busy_f === 1'b1) run_f++;
            if (done_f === 1'b1) begin
                if (fast_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL fast_unexpected_done: done=%b with no queued request at %0t", done_f, $time);
                end else begin
                    follow_f = fast_q.pop_front();
                    check("fast_busy_len", 32'(run_f), 32'd4);
                    chk_next_f = 1'b1;
                end
                run_f = 0;
            end
        end
    end

    task automatic issue(input logic w, input logic r, input logic [7:0] a, input logic [7:0] d,
                         input logic [7:0] rx, input int ab);
        txn_t t;
        t.wr = w;
        t.addr = a;
        t.data = d;
        t.rd_exp = rx;
        t.abort_cyc = ab;
        sb_q.push_back(t);
        req_wr = w;
        req_rd = r;
        addr = a;
        wr_data = d;
        @(posedge clock);
        #1;
        req_wr = 1'b0;
        req_rd = 1'b0;
        addr = 8'hEE;
        wr_data = 8'hEE;
    endtask

    task automatic wait_done(input string name, input int max);
        int n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (done !== 1'b1 && n < max);
        if (done !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: done=%b after %0d cycles, expected 1", name, done, n);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic wait_fast_done(input int max);
        int n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (done_f !== 1'b1 && n < max);
        if (done_f !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL fast_timeout: done=%b after %0d cycles, expected 1", done_f, n);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        mon_en = 1'b1;
        repeat (2) @(posedge clock);
        #1;

        // Fast instance: write request held high; three transactions, then release
        fast_q.push_back(1);
        fast_q.push_back(1);
        fast_q.push_back(0);
        req_wr_f = 1'b1;
        wait_fast_done(20);
        wait_fast_done(20);
        @(posedge clock);
        #1;
        req_wr_f = 1'b0;
        wait_fast_done(20);
        repeat (8) @(posedge clock);
        #1;

        // Plain write
        issue(1'b1, 1'b0, 8'h21, 8'h45, 8'h00, 0);
        wait_done("write", 40);
        repeat (2) @(posedge clock);
        #1;

        // Plain read
        rd_val = 8'h59;
        issue(1'b0, 1'b1, 8'h22, 8'h00, 8'h59, 0);
        wait_done("read", 40);
        repeat (2) @(posedge clock);
        #1;

        // Both requests together: the write runs
        issue(1'b1, 1'b1, 8'h31, 8'h67, 8'h00, 0);
        wait_done("both", 40);
        repeat (2) @(posedge clock);
        #1;

        // Read request pulsed in cycle 5 of a write must be ignored
        issue(1'b1, 1'b0, 8'h21, 8'h45, 8'h00, 0);
        repeat (4) @(posedge clock);
        #1;
        req_rd = 1'b1;
        addr = 8'h77;
        wr_data = 8'h88;
        @(posedge clock);
        #1;
        req_rd = 1'b0;
        wait_done("ignored_req", 40);
        repeat (30) @(posedge clock);
        #1;

        // Reset in cycle 15 of a read
        rd_val = 8'h13;
        issue(1'b0, 1'b1, 8'h24, 8'h00, 8'h13, 16);
        repeat (14) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (4) @(posedge clock);
        #1;

        // Recovery read after the reset
        rd_val = 8'h9C;
        issue(1'b0, 1'b1, 8'h25, 8'h00, 8'h9C, 0);
        wait_done("read_after_reset", 40);
        repeat (4) @(posedge clock);
        #1;

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        check("fast_drained", 32'(fast_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
